interrupt_controller: RTL



---
 rtl/intc_pkg.sv | 12 +
 rtl/priority_encoder_lsb.sv | 23 ++
 rtl/interrupt_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types and constants for the interrupt controller
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } intc_state_e;

    localparam int DEFAULT_CHANNELS = 8;

endpackage

// File: rtl/priority_encoder_lsb.sv
// rtl/priority_encoder_lsb.sv - lowest-set-bit priority encoder
module priority_encoder_lsb #(
    parameter int WIDTH = 8,
    parameter int IDW   = 3
) (
    input  logic [WIDTH-1:0] req_bits,
    output logic [IDW-1:0]   id,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_bits[i]) begin
                id    = IDW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - N-channel interrupt controller with req/ack/eoi handshake
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int                  CHANNELS   = DEFAULT_CHANNELS,
    parameter int                  IDW        = $clog2(CHANNELS),
    parameter logic [CHANNELS-1:0] EDGE_MASK  = {CHANNELS{1'b1}},
    parameter logic [CHANNELS-1:0] MASK_RESET = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] irq_in,
    input  logic                mask_we,
    input  logic [CHANNELS-1:0] mask_d,
    input  logic                ack,
    input  logic                eoi,
    output logic                int_req,
    output logic [IDW-1:0]      int_id,
    output logic                busy,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] mask
);

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CHANNELS-1:0] s2_d;
    logic [CHANNELS-1:0] set_bits;
    logic [CHANNELS-1:0] clr_bits;
    logic [CHANNELS-1:0] enabled;
    logic [IDW-1:0]      winner;
    logic                valid;
    logic                ack_hit;
    intc_state_e         state;
    intc_state_e         state_next;

    // Two-flop synchroniser plus one delayed sample for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            s2_d <= '0;
        end else begin
            s1   <= irq_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // Edge channels set on a rising synchronised sample, level channels while high
    assign set_bits = s2 & (~EDGE_MASK | ~s2_d);

    // The acknowledged channel is cleared in the same cycle the core takes it
    assign ack_hit = (state == REQ) && ack;

    // One-hot clear of the channel currently being acknowledged
    always_comb begin
        clr_bits = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            clr_bits[i] = ack_hit && (int_id == IDW'(i));
        end
    end

    // Pending latch: a fresh set beats a same-cycle clear so no edge is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= set_bits | (pending & ~clr_bits);
        end
    end

    // Software mask; masking gates requests but leaves pending untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= MASK_RESET;
        end else if (mask_we) begin
            mask <= mask_d;
        end
    end

    assign enabled = pending & mask;

    priority_encoder_lsb #(
        .WIDTH (CHANNELS),
        .IDW   (IDW)
    ) u_prio (
        .req_bits (enabled),
        .id       (winner),
        .valid    (valid)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: request, wait for ack, then hold off until eoi
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = REQ;
            REQ:     if (ack)   state_next = SERVICE;
            SERVICE: if (eoi)   state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        int_req = (state == REQ);
        busy    = (state == SERVICE);
    end

    // Channel id is captured once on issue and frozen through REQ and SERVICE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_id <= '0;
        end else if ((state == IDLE) && valid) begin
            int_id <= winner;
        end
    end

endmodule
